// File: rtl/fx3_stream_out_capture.sv
`default_nettype none
// ============================================================================
//  Module      : fx3_stream_out_capture
//  Description : Realigns FX3 slave-FIFO read data with the read strobe,
//                buffers words in a local FIFO, unpacks each 32-bit word into
//                two RGB565 pixels and throttles the read controller so the
//                FIFO never overflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx3_stream_out_capture #(
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 2,
  parameter int MARGIN     = 4
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     reading,
  input  logic [31:0]              stream_out_data_from_fx3,
  output logic                     stream_out_mode_selected,
  output logic [15:0]              pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2
  } unpack_state_t;

  logic [RD_LATENCY-1:0] rd_pipe;
  logic                  push;
  int                    pending;
  int                    free_words;

  logic [LVL_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      rd_ptr;
  logic [31:0]           mem [DEPTH];
  logic                  full;
  logic                  not_empty;
  logic                  push_ok;
  logic                  pop;

  unpack_state_t         state;
  unpack_state_t         state_next;
  logic                  load_word;
  logic                  load_high;
  logic [15:0]           high_half;

  // Shift register tracking which cycles will carry FX3 read data.
  generate
    if (RD_LATENCY == 1) begin : g_pipe_single
      // Single-stage latency pipe.
      always_ff @(posedge clk_100 or posedge reset) begin
        if (reset)      rd_pipe <= '0;
        else if (flush) rd_pipe <= '0;
        else            rd_pipe <= reading;
      end
    end else begin : g_pipe_multi
      // Multi-stage latency pipe, newest read enters at bit 0.
      always_ff @(posedge clk_100 or posedge reset) begin
        if (reset)      rd_pipe <= '0;
        else if (flush) rd_pipe <= '0;
        else            rd_pipe <= {rd_pipe[RD_LATENCY-2:0], reading};
      end
    end
  endgenerate

  assign push = rd_pipe[RD_LATENCY-1];

  // Count of reads still in flight, i.e. words that will arrive regardless.
  always_comb begin
    pending = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (rd_pipe[i]) pending = pending + 1;
    end
  end

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == LVL_W'(DEPTH));
  assign not_empty  = (fifo_level != '0);
  // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
  assign push_ok    = push && (!full || pop);

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk_100) begin
    if (push_ok && !flush) mem[wr_ptr[ADDR_W-1:0]] <= stream_out_data_from_fx3;
  end

  // Unpacker state register.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset)      state <= ST_EMPTY;
    else if (flush) state <= ST_EMPTY;
    else            state <= state_next;
  end

  // Unpacker next state, FIFO pop and pixel register load controls.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_word  = 1'b0;
    load_high  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (not_empty) begin
          pop        = 1'b1;
          load_word  = 1'b1;
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (pix_ready) begin
          load_high  = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (pix_ready) begin
          if (not_empty) begin
            // Fetch the next word right away so pixels stay back-to-back.
            pop        = 1'b1;
            load_word  = 1'b1;
            state_next = ST_LOW;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Pixel output register and holding register for the upper half-word.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      pix_data  <= '0;
      high_half <= '0;
    end else if (flush) begin
      pix_data  <= '0;
      high_half <= '0;
    end else if (load_word) begin
      {high_half, pix_data} <= mem[rd_ptr[ADDR_W-1:0]];
    end else if (load_high) begin
      pix_data <= high_half;
    end
  end

  assign pix_valid = (state != ST_EMPTY);

  // Space left once every in-flight read has landed.
  assign free_words = DEPTH - int'(fifo_level) - pending;

  // Registered read enable: drop it before in-flight plus late reads overfill.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) stream_out_mode_selected <= 1'b0;
    else       stream_out_mode_selected <= !flush && (free_words >= MARGIN);
  end

endmodule
`default_nettype wire

// File: tb/tb_fx3_stream_out_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx3_stream_out_capture
//  Description : Directed self-checking bench for fx3_stream_out_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx3_stream_out_capture;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        flush;
  logic        reading;
  logic        pix_ready;
  logic [31:0] fx3_data;
  logic        stream_out_mode_selected;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [4:0]  fifo_level;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  // FX3 bus model: reads reappear as data two cycles later.
  logic [1:0] fx_pipe;
  int words_issued;
  int words_sent;
  int pix_seen;

  always #5 clk_100 = ~clk_100;

  fx3_stream_out_capture #(
    .DEPTH(16),
    .RD_LATENCY(2),
    .MARGIN(4)
  ) dut (
    .clk_100                 (clk_100),
    .reset                   (reset),
    .flush                   (flush),
    .reading                 (reading),
    .stream_out_data_from_fx3(fx3_data),
    .stream_out_mode_selected(stream_out_mode_selected),
    .pix_data                (pix_data),
    .pix_valid               (pix_valid),
    .pix_ready               (pix_ready),
    .fifo_level              (fifo_level),
    .overflow                (overflow)
  );

  // Word k carries pixels 2k (low half) and 2k+1 (high half).
  function automatic logic [31:0] word_of(input int k);
    return {16'(2 * k + 1), 16'(2 * k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask

  // One clock cycle with the FX3 model driving the bus and pixels checked in order.
  task automatic cycle_model(input logic rd, input logic rdy);
    reading   = rd;
    pix_ready = rdy;
    if (fx_pipe[1]) begin
      fx3_data = word_of(words_sent);
      words_sent++;
    end else begin
      fx3_data = 32'hDEAD_BEEF;
    end
    if (pix_valid && rdy) begin
      check("pixel_order", {16'h0, pix_data}, 32'(pix_seen));
      pix_seen++;
    end
    tick;
    fx_pipe = {fx_pipe[0], rd};
    if (rd) words_issued++;
  endtask

  task automatic clear_model;
    fx_pipe      = 2'b00;
    words_issued = 0;
    words_sent   = 0;
    pix_seen     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int max_level;
    int first_cyc;
    int last_cyc;
    int valid_cnt;
    logic saw_low;

    reset     = 1'b1;
    flush     = 1'b0;
    reading   = 1'b0;
    pix_ready = 1'b0;
    fx3_data  = 32'h0;
    clear_model();

    // ---------------- reset then idle ----------------
    tick; tick; tick;
    check("rst_enable", {31'h0, stream_out_mode_selected}, 32'h0);
    check("rst_valid",  {31'h0, pix_valid}, 32'h0);
    check("rst_data",   {16'h0, pix_data}, 32'h0);
    check("rst_level",  {27'h0, fifo_level}, 32'h0);
    check("rst_ovf",    {31'h0, overflow}, 32'h0);
    reset = 1'b0;
    check("enable_release_cycle", {31'h0, stream_out_mode_selected}, 32'h0);
    tick;
    check("enable_after_release", {31'h0, stream_out_mode_selected}, 32'h1);
    tick;
    check("idle_valid", {31'h0, pix_valid}, 32'h0);

    // ---------------- single read ----------------
    reading = 1'b1;                       // cycle t
    tick;
    reading = 1'b0;                       // t+1
    tick;
    fx3_data = 32'hBBBB_AAAA;             // t+2
    tick;
    fx3_data = 32'h0;                     // t+3
    check("single_level_t3", {27'h0, fifo_level}, 32'h1);
    check("single_valid_t3", {31'h0, pix_valid}, 32'h0);
    tick;                                 // t+4
    check("single_level_t4", {27'h0, fifo_level}, 32'h0);
    check("single_valid_t4", {31'h0, pix_valid}, 32'h1);
    check("single_low",      {16'h0, pix_data}, 32'h0000_AAAA);
    pix_ready = 1'b1;
    tick;                                 // t+5
    check("single_valid_t5", {31'h0, pix_valid}, 32'h1);
    check("single_high",     {16'h0, pix_data}, 32'h0000_BBBB);
    tick;                                 // t+6
    check("single_valid_t6", {31'h0, pix_valid}, 32'h0);
    pix_ready = 1'b0;

    // ---------------- continuous burst, ready held high ----------------
    clear_model();
    max_level = 0;
    first_cyc = -1;
    last_cyc  = -1;
    valid_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (pix_valid) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        valid_cnt++;
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      cycle_model((c < 16) && (c % 2 == 0), 1'b1);
    end
    check("burst_pixels",     32'(pix_seen), 32'd16);
    check("burst_valid_cnt",  32'(valid_cnt), 32'd16);
    check("burst_gap_free",   32'(last_cyc - first_cyc), 32'd15);
    check("burst_level_max",  32'(max_level), 32'd1);

    // ---------------- backpressure with an obedient reader ----------------
    clear_model();
    max_level = 0;
    saw_low   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stream_out_mode_selected) saw_low = 1'b1;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      cycle_model(stream_out_mode_selected && (words_issued < 20), 1'b0);
    end
    check("bp_enable_fell", {31'h0, saw_low}, 32'h1);
    check("bp_peak_level",  32'(max_level), 32'd14);
    check("bp_words_read",  32'(words_issued), 32'd15);
    check("bp_no_overflow", {31'h0, overflow}, 32'h0);
    for (int c = 0; c < 300 && pix_seen < 40; c++) begin
      cycle_model(stream_out_mode_selected && (words_issued < 20), 1'b1);
    end
    check("bp_all_delivered", 32'(pix_seen), 32'd40);
    check("bp_drained_level", {27'h0, fifo_level}, 32'h0);
    check("bp_no_overflow_end", {31'h0, overflow}, 32'h0);

    // ---------------- forced overflow then flush ----------------
    clear_model();
    for (int c = 0; c < 20; c++) begin
      if (c == 19) begin
        check("ovf_full_level", {27'h0, fifo_level}, 32'd16);
        check("ovf_not_yet",    {31'h0, overflow}, 32'h0);
      end
      cycle_model(1'b1, 1'b0);
    end
    for (int c = 0; c < 4; c++) cycle_model(1'b0, 1'b0);
    check("ovf_level",   {27'h0, fifo_level}, 32'd16);
    check("ovf_flag",    {31'h0, overflow}, 32'h1);
    check("ovf_valid",   {31'h0, pix_valid}, 32'h1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_ovf",    {31'h0, overflow}, 32'h0);
    check("flush_level",  {27'h0, fifo_level}, 32'h0);
    check("flush_valid",  {31'h0, pix_valid}, 32'h0);
    check("flush_enable", {31'h0, stream_out_mode_selected}, 32'h0);
    tick;

    // ---------------- async reset mid-burst ----------------
    clear_model();
    words_sent = 5;
    for (int c = 0; c < 30 && fifo_level != 5'd7; c++) cycle_model(1'b1, 1'b0);
    check("mid_level_seven", {27'h0, fifo_level}, 32'd7);
    check("mid_pix_data",    {16'h0, pix_data}, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    check("async_level",  {27'h0, fifo_level}, 32'h0);
    check("async_valid",  {31'h0, pix_valid}, 32'h0);
    check("async_data",   {16'h0, pix_data}, 32'h0);
    check("async_enable", {31'h0, stream_out_mode_selected}, 32'h0);
    check("async_ovf",    {31'h0, overflow}, 32'h0);
    reading = 1'b0;
    #3;
    reset = 1'b0;
    tick;
    clear_model();
    cycle_model(1'b1, 1'b1);
    for (int c = 0; c < 10; c++) cycle_model(1'b0, 1'b1);
    check("resume_pixels", 32'(pix_seen), 32'd2);
    check("resume_level",  {27'h0, fifo_level}, 32'h0);
    check("resume_enable", {31'h0, stream_out_mode_selected}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
